// File: rtl/even_odd_counter.sv
// even_odd_counter: counts even and odd 32-bit words over a frame and reports
// the two totals through a valid/ready handshake. A frame closes after
// FRAME_LEN accepted words or on an accepted word flagged with in_last.
module even_odd_counter #(
    parameter int FRAME_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_even,
    output logic [15:0] out_odd,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);

    state_t      state_q, state_d;
    logic [15:0] even_cnt_q, odd_cnt_q, word_cnt_q;
    logic [15:0] out_even_q, out_odd_q;
    logic        out_valid_q;

    logic        accept;
    logic        word_is_odd;
    logic        close_frame;
    logic [15:0] word_cnt_inc, even_cnt_inc, odd_cnt_inc;

    // Only bit 0 decides the class; the upper bits are deliberately unused.
    logic unused_data_bits;
    assign unused_data_bits = ^in_data[31:1];

    // Accept qualification and the counts as they will be after this word.
    always_comb begin
        accept       = in_valid && in_ready;
        word_is_odd  = in_data[0];
        word_cnt_inc = word_cnt_q + 16'd1;
        even_cnt_inc = even_cnt_q + {15'd0, ~word_is_odd};
        odd_cnt_inc  = odd_cnt_q + {15'd0, word_is_odd};
        close_frame  = accept && ((word_cnt_inc == FRAME_LEN_W) || in_last);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave COLLECT on a closing accept, leave REPORT on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (close_frame) state_d = REPORT;
            REPORT:  if (out_ready)   state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output decode: in_ready depends on state alone, so no input reaches it.
    always_comb begin
        in_ready = (state_q == COLLECT);
    end

    // Frame counters and result registers; a closing word is folded into the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            even_cnt_q  <= 16'd0;
            odd_cnt_q   <= 16'd0;
            word_cnt_q  <= 16'd0;
            out_even_q  <= 16'd0;
            out_odd_q   <= 16'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (close_frame) begin
                out_even_q  <= even_cnt_inc;
                out_odd_q   <= odd_cnt_inc;
                out_valid_q <= 1'b1;
                even_cnt_q  <= 16'd0;
                odd_cnt_q   <= 16'd0;
                word_cnt_q  <= 16'd0;
            end else if (accept) begin
                even_cnt_q  <= even_cnt_inc;
                odd_cnt_q   <= odd_cnt_inc;
                word_cnt_q  <= word_cnt_inc;
            end else if ((state_q == REPORT) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_even  = out_even_q;
    assign out_odd   = out_odd_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_even_odd_counter.sv
// Bench for even_odd_counter: four instances with FRAME_LEN 4, 8, 2 and 1
// share clock and reset; each scenario task drives one instance, pushes the
// expected frame totals onto a scoreboard and pops them when the result shows.
module tb_even_odd_counter;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data   [4];
    logic        in_valid  [4];
    logic        in_last   [4];
    logic        in_ready  [4];
    logic [15:0] out_even  [4];
    logic [15:0] out_odd   [4];
    logic        out_valid [4];
    logic        out_ready [4];

    // Instance map: 0 -> FRAME_LEN 4, 1 -> 8, 2 -> 2, 3 -> 1.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            even_odd_counter #(
                .FRAME_LEN((gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 2 : 1)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_data  (in_data[gi]),
                .in_valid (in_valid[gi]),
                .in_last  (in_last[gi]),
                .in_ready (in_ready[gi]),
                .out_even (out_even[gi]),
                .out_odd  (out_odd[gi]),
                .out_valid(out_valid[gi]),
                .out_ready(out_ready[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [15:0] e;
        logic [15:0] o;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word on an instance; it is sampled at the next edge.
    task automatic drive(input int sel, input logic [31:0] d, input logic v, input logic l);
        in_data[sel]  = d;
        in_valid[sel] = v;
        in_last[sel]  = l;
    endtask

    task automatic push_exp(input int sel, input int e, input int o);
        exp_t x;
        x.inst = sel;
        x.e    = 16'(e);
        x.o    = 16'(o);
        sb.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i, 32'd0, 1'b0, 1'b0);
            out_ready[i] = 1'b1;
        end
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 ||
                out_even[i] !== 16'd0 || out_odd[i] !== 16'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d actual rdy=%b vld=%b even=%0d odd=%0d required rdy=1 vld=0 even=0 odd=0",
                         i, in_ready[i], out_valid[i], out_even[i], out_odd[i]);
            end
        end
        rst_n = 1'b1;
        step();
        $display("reset released");
    endtask

    // FRAME_LEN=4, words 0..3 back to back, consumer always ready.
    task automatic test_basic();
        exp_t x;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'(i), 1'b1, 1'b0);
            if (i == 3) push_exp(0, 2, 2);
            step();
            $display("basic inst=0 word=%0d", i);
            if (i < 3) begin
                checks++;
                if (out_valid[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid word=%0d actual=%b required=0", i, out_valid[0]);
                end
            end
        end
        drive(0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL basic_report_latency actual vld=%b rdy=%b required vld=1 rdy=0", out_valid[0], in_ready[0]);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL basic_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL basic_counts actual even=%0d odd=%0d required even=%0d odd=%0d",
                         out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        step();
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle actual vld=%b rdy=%b required vld=0 rdy=1", out_valid[0], in_ready[0]);
        end
    endtask

    // FRAME_LEN=8, words 5,9,7 with in_last on 7; report held until handshake.
    task automatic test_last();
        exp_t     x;
        int       words [3] = '{5, 9, 7};
        out_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(words[i]), 1'b1, (i == 2));
            if (i == 2) push_exp(1, 0, 3);
            step();
            $display("last inst=1 word=%0d last=%0d", words[i], (i == 2));
        end
        drive(1, 32'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
                failures++;
                $display("FAIL last_hold cycle=%0d actual vld=%b rdy=%b required vld=1 rdy=0", c, out_valid[1], in_ready[1]);
            end
            if (c < 2) step();
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL last_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL last_counts actual even=%0d odd=%0d required even=%0d odd=%0d",
                         out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        out_ready[1] = 1'b1;
        step();
        checks++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            failures++;
            $display("FAIL last_handshake actual vld=%b rdy=%b required vld=0 rdy=1", out_valid[1], in_ready[1]);
        end
    endtask

    // FRAME_LEN=2: backpressure with in_valid held high, then a fresh frame.
    task automatic test_backpressure();
        exp_t x;
        out_ready[2] = 1'b0;
        drive(2, 32'd4, 1'b1, 1'b0);
        step();
        drive(2, 32'd6, 1'b1, 1'b0);
        push_exp(2, 2, 0);
        step();
        $display("bp inst=2 words=4,6");
        // Odd words offered while blocked must not be counted anywhere.
        drive(2, 32'd1, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 ||
                out_even[2] !== 16'd2 || out_odd[2] !== 16'd0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d actual vld=%b rdy=%b even=%0d odd=%0d required vld=1 rdy=0 even=2 odd=0",
                         c, out_valid[2], in_ready[2], out_even[2], out_odd[2]);
            end
            step();
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL bp_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL bp_counts actual even=%0d odd=%0d required even=%0d odd=%0d",
                         out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        // Handshake edge with word 1 still offered: it is taken on the next edge only.
        out_ready[2] = 1'b1;
        step();
        checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake actual vld=%b rdy=%b required vld=0 rdy=1", out_valid[2], in_ready[2]);
        end
        step();
        drive(2, 32'd3, 1'b1, 1'b0);
        push_exp(2, 0, 2);
        step();
        drive(2, 32'd0, 1'b0, 1'b0);
        $display("bp inst=2 words=1,3");
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL bp_next_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_valid[x.inst] !== 1'b1 || out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL bp_next_frame actual vld=%b even=%0d odd=%0d required vld=1 even=%0d odd=%0d",
                         out_valid[x.inst], out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        step();
    endtask

    // FRAME_LEN=4, in_valid alternating; idle cycles carry odd junk data.
    task automatic test_gaps();
        exp_t x;
        int   words [4] = '{1, 3, 8, 10};
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'(words[i]), 1'b1, 1'b0);
            if (i == 3) push_exp(0, 2, 2);
            step();
            $display("gaps inst=0 word=%0d", words[i]);
            if (i < 3) begin
                drive(0, 32'd5, 1'b0, 1'b1);
                step();
                checks++;
                if (out_valid[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL gaps_early_valid after_word=%0d actual=%b required=0", i, out_valid[0]);
                end
            end
        end
        drive(0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL gaps_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_valid[x.inst] !== 1'b1 || out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL gaps_counts actual vld=%b even=%0d odd=%0d required vld=1 even=%0d odd=%0d",
                         out_valid[x.inst], out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        step();
    endtask

    // Reset mid-frame on instance 0 and during REPORT on instance 3.
    task automatic test_reset_mid();
        exp_t x;
        out_ready[3] = 1'b0;
        drive(3, 32'd2, 1'b1, 1'b0);
        step();
        drive(3, 32'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid[3] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pending actual=%b required=1", out_valid[3]);
        end
        out_ready[0] = 1'b1;
        drive(0, 32'd1, 1'b1, 1'b0);
        step();
        step();
        drive(0, 32'd0, 1'b0, 1'b0);
        $display("rstmid inst=0 two words accepted, asserting reset");
        // Assert between edges: the clear must not wait for a clock.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_even[0] !== 16'd0 || out_odd[0] !== 16'd0 || in_ready[0] !== 1'b1 ||
            out_valid[3] !== 1'b0 || in_ready[3] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async actual even0=%0d odd0=%0d rdy0=%b vld3=%b rdy3=%b required 0 0 1 0 1",
                     out_even[0], out_odd[0], in_ready[0], out_valid[3], in_ready[3]);
        end
        #2;
        rst_n = 1'b1;
        out_ready[3] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'd0, 1'b1, 1'b0);
            if (i == 3) push_exp(0, 4, 0);
            step();
            if (i < 3) begin
                checks++;
                if (out_valid[0] !== 1'b0 || out_valid[3] !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_stale word=%0d actual vld0=%b vld3=%b required 0 0", i, out_valid[0], out_valid[3]);
                end
            end
        end
        drive(0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL rstmid_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_valid[x.inst] !== 1'b1 || out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL rstmid_counts actual vld=%b even=%0d odd=%0d required vld=1 even=%0d odd=%0d",
                         out_valid[x.inst], out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        step();
    endtask

    // FRAME_LEN=1: each word is its own frame; extreme values exercise bit 0 only.
    task automatic test_frame_len1();
        exp_t x;
        out_ready[3] = 1'b1;
        drive(3, 32'hFFFF_FFFE, 1'b1, 1'b0);
        push_exp(3, 1, 0);
        step();
        drive(3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL len1_first_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_valid[x.inst] !== 1'b1 || out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL len1_first actual vld=%b even=%0d odd=%0d required vld=1 even=%0d odd=%0d",
                         out_valid[x.inst], out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        step();
        checks++;
        if (out_valid[3] !== 1'b0 || in_ready[3] !== 1'b1) begin
            failures++;
            $display("FAIL len1_handshake actual vld=%b rdy=%b required vld=0 rdy=1", out_valid[3], in_ready[3]);
        end
        push_exp(3, 0, 1);
        step();
        drive(3, 32'd0, 1'b0, 1'b0);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL len1_second_scoreboard actual=empty required=entry");
        end else begin
            x = sb.pop_front();
            $display("report inst=%0d even=%0d odd=%0d", x.inst, out_even[x.inst], out_odd[x.inst]);
            if (out_valid[x.inst] !== 1'b1 || out_even[x.inst] !== x.e || out_odd[x.inst] !== x.o) begin
                failures++;
                $display("FAIL len1_second actual vld=%b even=%0d odd=%0d required vld=1 even=%0d odd=%0d",
                         out_valid[x.inst], out_even[x.inst], out_odd[x.inst], x.e, x.o);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_frame_len1();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/even_odd_counter.md
EVEN_ODD_COUNTER -- requirements
Module: even_odd_counter

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, meaning the number of accepted words per frame (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  32  the unsigned number to classify.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_last  input  1  the current word closes the frame early; sampled only on accept.
REQ-007 SHALL have port in_ready  output  1  the block can accept a word this cycle.
REQ-008 SHALL have port out_even  output  16  count of even words in the reported frame.
REQ-009 SHALL have port out_odd  output  16  count of odd words in the reported frame.
REQ-010 SHALL have port out_valid  output  1  out_even/out_odd hold a completed frame result.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the result this cycle.

Function
REQ-012 SHALL classify a word as even when in_data[0]=0 and odd when in_data[0]=1; no other bits affect the classification.
REQ-013 SHALL implement a two-state FSM: COLLECT and REPORT.
REQ-014 SHALL drive in_ready=1 in COLLECT and in_ready=0 in REPORT; in_ready SHALL be decoded from state only, with no combinational path from any input.
REQ-015 SHALL accept a word only on a rising edge where in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL leave all counters unchanged.
REQ-016 SHALL, on each accept in COLLECT, increment either the internal even counter or the internal odd counter (never both), together with an internal word counter.
REQ-017 SHALL close the frame on the accept where the word counter reaches FRAME_LEN, or where in_last=1, whichever comes first.
REQ-018 SHALL, on the closing edge, load out_even and out_odd with the final counts including the closing word, set out_valid=1, clear the internal counters, and enter REPORT; out_valid SHALL therefore be visible in the cycle after the closing accept.
REQ-019 SHALL guarantee out_even+out_odd equals the number of words accepted in the frame.
REQ-020 SHALL, in REPORT, hold out_even, out_odd and out_valid stable for as long as out_ready=0.
REQ-021 SHALL, on a rising edge in REPORT with out_ready=1, clear out_valid and return to COLLECT; the first word of the next frame SHALL be accepted no earlier than the following cycle.
REQ-022 SHALL leave out_even and out_odd at their last reported values while in COLLECT; consumers SHALL qualify them with out_valid.
REQ-023 SHALL ignore out_ready while in COLLECT.
REQ-024 SHALL, with FRAME_LEN=1, close every accepted word as its own frame.

Reset
REQ-025 SHALL, while rst_n=0 and independently of clk, force the state to COLLECT, out_valid=0, out_even=0, out_odd=0, and all internal counters to 0; in_ready therefore reads 1 during reset.
REQ-026 SHALL, when reset is asserted mid-frame or during REPORT, discard the partial frame or the pending result; no stale result SHALL appear after reset is released.

Verification
REQ-027 FRAME_LEN=4, words 0,1,2,3 on consecutive cycles, out_ready=1 -> out_valid=1 for one cycle, starting the cycle after word 3, with out_even=2 and out_odd=2.
REQ-028 FRAME_LEN=8, words 5,9,7 with in_last=1 on word 7 -> out_even=0, out_odd=3, and in_ready=0 until the handshake.
REQ-029 FRAME_LEN=2, words 4,6, out_ready held at 0 for 5 cycles with in_valid=1 -> outputs stay at out_even=2, out_odd=0, no words are accepted, and the next frame counts from 0 after the handshake.
REQ-030 FRAME_LEN=4, in_valid toggling 1,0,1,0,... carrying words 1,3,8,10 -> out_even=2, out_odd=2; the idle cycles are not counted.
REQ-031 FRAME_LEN=4, rst_n pulsed low after 2 accepted words, then four words of value 0 -> a single report with out_even=4, out_odd=0.
REQ-032 FRAME_LEN=1, words 0xFFFFFFFE then 0xFFFFFFFF -> two reports: the first with out_even=1 and out_odd=0, the second with out_even=0 and out_odd=1.
